// File: rtl/manchester_pkg.sv
`default_nettype none
// ============================================================================
// Module   : manchester_pkg
// Purpose  : Shared constants, FSM encoding and the half-bit level helper for
//            the Manchester word encoder family.
// Contents : POL_THOMAS / POL_IEEE  - encoding polarity selectors
//            ST_IDLE / ST_SHIFT      - encoder FSM state codes (state_t)
//            halfbit_level()         - line level for a (bit, half, polarity)
// Revision : 1.0 - initial release
// ============================================================================
package manchester_pkg;

    // Polarity selectors: Thomas sends 1 as high-then-low, IEEE 802.3 the reverse.
    localparam bit POL_THOMAS = 1'b0;
    localparam bit POL_IEEE   = 1'b1;

    // Encoder FSM state codes.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_SHIFT = 1'b1;

    // Line level for one half of a Manchester bit. The first half carries the
    // data bit (inverted for IEEE), the second half its complement, so every
    // bit has a mid-bit transition.
    function automatic logic halfbit_level(input logic data_bit,
                                           input logic second_half,
                                           input logic polarity);
        logic first_level;
        first_level = data_bit ^ polarity;
        return second_half ? ~first_level : first_level;
    endfunction

endpackage : manchester_pkg
`default_nettype wire

// File: rtl/manchester_word_encoder_if.sv
`default_nettype none
// ============================================================================
// Module   : manchester_word_encoder_if
// Purpose  : Word valid/ready handshake between a word producer and the
//            Manchester word encoder.
// Signals  : word_in    - word to send (DATA_W bits), producer -> encoder
//            word_valid - word_in is valid, producer -> encoder
//            word_ready - encoder holding register can accept, encoder -> producer
// Modports : master (producer), slave (encoder)
// Revision : 1.0 - initial release
// ============================================================================
interface manchester_word_encoder_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (output word_in, output word_valid, input word_ready);
    modport slave  (input word_in, input word_valid, output word_ready);
endinterface : manchester_word_encoder_if
`default_nettype wire

// File: rtl/manchester_halfbit_timer.sv
`default_nettype none
// ============================================================================
// Module   : manchester_halfbit_timer
// Purpose  : Half-bit timing for Manchester encode/decode. While run is high it
//            counts HALF_CLKS clocks per half-bit and toggles the phase.
//            Dropping run returns it to the start of a bit.
// Ports    : clk_sys  in  system clock
//            rst      in  asynchronous active-high reset
//            run      in  timer advances while high, cleared while low
//            half     out 0 = first half of the bit, 1 = second half
//            half_end out last clock of the current half-bit
//            bit_end  out last clock of the second half (end of the bit)
// Revision : 1.0 - initial release
// ============================================================================
module manchester_halfbit_timer #(
    parameter int HALF_CLKS = 2
) (
    input  wire  clk_sys,
    input  wire  rst,
    input  wire  run,
    output logic half,
    output logic half_end,
    output logic bit_end
);

    localparam int c_cnt_w = (HALF_CLKS > 1) ? $clog2(HALF_CLKS) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(HALF_CLKS - 1);

    logic [c_cnt_w-1:0] half_cnt_q, half_cnt_d;
    logic               half_q, half_d;
    logic               w_wrap;

    assign w_wrap = run & (half_cnt_q == c_last_cnt);

    always_comb begin
        half_cnt_d = half_cnt_q;
        half_d     = half_q;
        if (!run) begin
            half_cnt_d = '0;
            half_d     = 1'b0;
        end else if (w_wrap) begin
            half_cnt_d = '0;
            half_d     = ~half_q;
        end else begin
            half_cnt_d = half_cnt_q + c_cnt_w'(1);
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            half_cnt_q <= '0;
            half_q     <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            half_q     <= half_d;
        end
    end

    assign half     = half_q;
    assign half_end = w_wrap;
    assign bit_end  = w_wrap & half_q;

endmodule : manchester_halfbit_timer
`default_nettype wire

// File: rtl/manchester_word_encoder.sv
`default_nettype none
// ============================================================================
// Module   : manchester_word_encoder
// Purpose  : Serialises DATA_W-bit words into a Manchester-coded complementary
//            pair. A one-word holding register lets words stream back to back
//            with no idle gap. An underrun is flagged when the stream starves.
// Ports    : clk_sys    in  system clock
//            rst        in  asynchronous active-high reset
//            tx_en      in  transmit enable, low aborts and flushes
//            word_if    --  slave side of word_in / word_valid / word_ready
//            ddr_p      out Manchester output, registered
//            ddr_n      out complement of ddr_p, registered
//            busy       out a word is on the line
//            underrun   out one-cycle pulse on the first idle cycle after a
//                           stream ends with nothing queued
// Revision : 1.0 - initial release
// ============================================================================
module manchester_word_encoder
    import manchester_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int HALF_CLKS  = 2,
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit POLARITY   = POL_THOMAS,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  wire                          clk_sys,
    input  wire                          rst,
    input  wire                          tx_en,
    manchester_word_encoder_if.slave     word_if,
    output logic                         ddr_p,
    output logic                         ddr_n,
    output logic                         busy,
    output logic                         underrun
);

    localparam int c_bit_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(DATA_W - 1);

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [c_bit_w-1:0]  bit_cnt_q, bit_cnt_d;
    logic                ddr_p_q, ddr_p_d;
    logic                ddr_n_q, ddr_n_d;
    logic                busy_q, busy_d;
    logic                underrun_q, underrun_d;
    logic                underrun_pend_q, underrun_pend_d;
    logic                rdy_en_q;

    logic                w_run;
    logic                w_half;
    logic                w_bit_end;
    logic                w_half_end_unused;
    logic                w_cur_bit;
    logic [DATA_W-1:0]   w_shift_next;
    logic                w_accept;

    // rdy_en_q keeps word_ready low while in reset and for the first clock
    // after it, so nothing is accepted before the datapath is out of reset.
    assign word_if.word_ready = tx_en & ~hold_full_q & rdy_en_q;
    assign w_accept           = word_if.word_valid & word_if.word_ready;

    assign w_run = (state_q == ST_SHIFT) & tx_en;

    // Only the bit strobe steers the shifter. The half strobe is for the
    // decoder's reference timing.
    manchester_halfbit_timer #(
        .HALF_CLKS (HALF_CLKS)
    ) u_timer (
        .clk_sys  (clk_sys),
        .rst      (rst),
        .run      (w_run),
        .half     (w_half),
        .half_end (w_half_end_unused),
        .bit_end  (w_bit_end)
    );

    if (MSB_FIRST) begin : g_msb_first
        assign w_cur_bit    = shift_q[DATA_W-1];
        assign w_shift_next = shift_q << 1;
    end else begin : g_lsb_first
        assign w_cur_bit    = shift_q[0];
        assign w_shift_next = shift_q >> 1;
    end

    // ddr_p_d is the level for the current state, so the line lags the FSM by
    // one clock. That gives the 2-cycle accept-to-line latency. It also
    // explains why underrun is staged through underrun_pend_q: the pulse must
    // land on the first idle-level cycle, not the last data cycle.
    always_comb begin
        state_d         = state_q;
        hold_d          = hold_q;
        hold_full_d     = hold_full_q;
        shift_d         = shift_q;
        bit_cnt_d       = bit_cnt_q;
        ddr_p_d         = IDLE_LEVEL;
        busy_d          = 1'b0;
        underrun_d      = 1'b0;
        underrun_pend_d = 1'b0;

        if (tx_en) begin
            underrun_d = underrun_pend_q;
            case (state_q)
                ST_IDLE: begin
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        bit_cnt_d   = '0;
                        state_d     = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    ddr_p_d = halfbit_level(w_cur_bit, w_half, POLARITY);
                    busy_d  = 1'b1;
                    if (w_bit_end) begin
                        if (bit_cnt_q == c_last_bit) begin
                            bit_cnt_d = '0;
                            if (hold_full_q) begin
                                shift_d     = hold_q;
                                hold_full_d = 1'b0;
                            end else begin
                                shift_d         = '0;
                                state_d         = ST_IDLE;
                                underrun_pend_d = 1'b1;
                            end
                        end else begin
                            shift_d   = w_shift_next;
                            bit_cnt_d = bit_cnt_q + c_bit_w'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // Applied after the reload so a same-edge consume and refill
            // leaves the holding register full.
            if (w_accept) begin
                hold_d      = word_if.word_in;
                hold_full_d = 1'b1;
            end
        end else begin
            state_d     = ST_IDLE;
            hold_full_d = 1'b0;
            shift_d     = '0;
            bit_cnt_d   = '0;
        end

        ddr_n_d = ~ddr_p_d;
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            hold_q          <= '0;
            hold_full_q     <= 1'b0;
            shift_q         <= '0;
            bit_cnt_q       <= '0;
            ddr_p_q         <= IDLE_LEVEL;
            ddr_n_q         <= ~IDLE_LEVEL;
            busy_q          <= 1'b0;
            underrun_q      <= 1'b0;
            underrun_pend_q <= 1'b0;
            rdy_en_q        <= 1'b0;
        end else begin
            state_q         <= state_d;
            hold_q          <= hold_d;
            hold_full_q     <= hold_full_d;
            shift_q         <= shift_d;
            bit_cnt_q       <= bit_cnt_d;
            ddr_p_q         <= ddr_p_d;
            ddr_n_q         <= ddr_n_d;
            busy_q          <= busy_d;
            underrun_q      <= underrun_d;
            underrun_pend_q <= underrun_pend_d;
            rdy_en_q        <= 1'b1;
        end
    end

    assign ddr_p    = ddr_p_q;
    assign ddr_n    = ddr_n_q;
    assign busy     = busy_q;
    assign underrun = underrun_q;

endmodule : manchester_word_encoder
`default_nettype wire

// File: tb/tb_manchester_word_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_manchester_word_encoder
// Purpose  : Self-checking bench for manchester_word_encoder. DUT a uses the
//            default configuration. DUT b is 4-bit, LSB-first, IEEE, 3 clocks
//            per half-bit, idle high. Expected line streams come from a
//            word-level Manchester model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_manchester_word_encoder;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx_en_a, tx_en_b;
    logic ddr_p_a, ddr_n_a, busy_a, und_a;
    logic ddr_p_b, ddr_n_b, busy_b, und_b;

    always #5 clk = ~clk;

    manchester_word_encoder_if #(.DATA_W(8)) if_a ();
    manchester_word_encoder_if #(.DATA_W(4)) if_b ();

    manchester_word_encoder u_dut_a (
        .clk_sys  (clk),
        .rst      (rst),
        .tx_en    (tx_en_a),
        .word_if  (if_a.slave),
        .ddr_p    (ddr_p_a),
        .ddr_n    (ddr_n_a),
        .busy     (busy_a),
        .underrun (und_a)
    );

    manchester_word_encoder #(
        .DATA_W     (4),
        .HALF_CLKS  (3),
        .MSB_FIRST  (1'b0),
        .POLARITY   (1'b1),
        .IDLE_LEVEL (1'b1)
    ) u_dut_b (
        .clk_sys  (clk),
        .rst      (rst),
        .tx_en    (tx_en_b),
        .word_if  (if_b.slave),
        .ddr_p    (ddr_p_b),
        .ddr_n    (ddr_n_b),
        .busy     (busy_b),
        .underrun (und_b)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    logic        exp_q[$];
    int          rec_cyc[$];
    logic [3:0]  rec_q[$];
    int          acc_first;
    int          rec_base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ddr_p, ddr_n, busy, underrun}
    function automatic logic [3:0] quad(input int sel);
        return (sel != 0) ? {ddr_p_b, ddr_n_b, busy_b, und_b}
                          : {ddr_p_a, ddr_n_a, busy_a, und_a};
    endfunction

    function automatic logic rdy(input int sel);
        return (sel != 0) ? if_b.word_ready : if_a.word_ready;
    endfunction

    function automatic logic [3:0] idle_quad(input int sel);
        return (sel != 0) ? 4'b1000 : 4'b0100;
    endfunction

    // Word-level model: every bit becomes HALF_CLKS clocks of its first-half
    // level followed by HALF_CLKS clocks of the complement.
    function automatic void build_model(input int sel, input logic [31:0] words[$]);
        int   dw, h;
        bit   msb, pol;
        logic b, lvl;
        dw  = (sel != 0) ? 4 : 8;
        h   = (sel != 0) ? 3 : 2;
        msb = (sel == 0);
        pol = (sel != 0);
        exp_q.delete();
        foreach (words[i]) begin
            for (int k = 0; k < dw; k++) begin
                b = words[i][msb ? (dw - 1 - k) : k];
                for (int hf = 0; hf < 2; hf++) begin
                    lvl = (hf == 0) ? (b ^ pol) : ~(b ^ pol);
                    for (int c = 0; c < h; c++) exp_q.push_back(lvl);
                end
            end
        end
    endfunction

    task automatic push(input int sel, input logic [31:0] w);
        int t;
        t = 0;
        if (sel != 0) begin
            if_b.word_in = w[3:0];
            if_b.word_valid = 1'b1;
        end else begin
            if_a.word_in = w[7:0];
            if_a.word_valid = 1'b1;
        end
        @(negedge clk);
        while (!rdy(sel) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("push_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (acc_first < 0) acc_first = cyc;
        if (sel != 0) if_b.word_valid = 1'b0;
        else          if_a.word_valid = 1'b0;
    endtask

    function automatic logic [31:0] grab_bits(input int n);
        logic [31:0] v;
        int idx;
        v = '0;
        foreach (rec_q[k]) begin
            idx = rec_cyc[k] - rec_base;
            if (idx >= 0 && idx < n) v[n - 1 - idx] = rec_q[k][3];
        end
        return v;
    endfunction

    function automatic int count_busy();
        int s;
        s = 0;
        foreach (rec_q[k]) s += int'(rec_q[k][1]);
        return s;
    endfunction

    // Sends words as fast as the DUT accepts them, records every cycle and
    // compares against the model: idle before, contiguous data, one underrun.
    task automatic run_stream(input int sel, input logic [31:0] words[$],
                              input bit raise, input string tag);
        int         start, len, idx;
        logic [3:0] e;
        build_model(sel, words);
        len = exp_q.size();
        rec_cyc.delete();
        rec_q.delete();
        @(posedge clk);
        #1;
        if (raise) begin
            if (sel != 0) tx_en_b = 1'b1;
            else          tx_en_a = 1'b1;
        end
        start     = cyc;
        acc_first = -1;
        fork
            begin
                foreach (words[i]) push(sel, words[i]);
            end
            begin
                for (int k = 0; k < len + 7; k++) begin
                    @(negedge clk);
                    rec_cyc.push_back(cyc);
                    rec_q.push_back(quad(sel));
                end
            end
        join
        check({tag, "_accept_lat"}, acc_first - start, 32'd1);
        rec_base = acc_first + 2;
        foreach (rec_q[k]) begin
            idx = rec_cyc[k] - rec_base;
            if (idx >= 0 && idx < len) e = {exp_q[idx], ~exp_q[idx], 1'b1, 1'b0};
            else                       e = idle_quad(sel) | {3'b000, idx == len};
            check($sformatf("%s_cyc%0d", tag, idx), rec_q[k], e);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] ws[$];
        logic [7:0]  r;
        int          t;

        tx_en_a = 1'b1;
        tx_en_b = 1'b1;
        if_a.word_in = '0; if_a.word_valid = 1'b0;
        if_b.word_in = '0; if_b.word_valid = 1'b0;

        // Reset state
        #1 rst = 1'b1;
        #1;
        check("rst_quad_a", quad(0), 4'b0100);
        check("rst_quad_b", quad(1), 4'b1000);
        check("rst_ready_a", rdy(0), 1'b0);
        check("rst_ready_b", rdy(1), 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // 0xA5 single word, default configuration
        ws = {};
        ws.push_back(32'hA5);
        run_stream(0, ws, 1'b0, "a5");
        check("a5_pattern", grab_bits(32), 32'b1100_0011_1100_0011_0011_1100_0011_1100);

        // Back-to-back 0xFF, 0x00: 64 contiguous encoded clocks
        ws = {};
        ws.push_back(32'hFF);
        ws.push_back(32'h00);
        run_stream(0, ws, 1'b0, "b2b");
        check("b2b_busy_cycles", count_busy(), 32'd64);

        // Random streams on the default configuration
        repeat (4) begin
            ws = {};
            repeat ($urandom_range(1, 3)) ws.push_back(32'($urandom_range(0, 255)));
            run_stream(0, ws, 1'b0, "rnd_a");
        end

        // IEEE, LSB-first, HALF_CLKS=3, 4-bit word 0x1
        ws = {};
        ws.push_back(32'h1);
        run_stream(1, ws, 1'b0, "ieee1");
        check("ieee1_pattern", grab_bits(24), 32'b000111_111000_111000_111000);

        repeat (4) begin
            ws = {};
            repeat ($urandom_range(1, 3)) ws.push_back(32'($urandom_range(0, 15)));
            run_stream(1, ws, 1'b0, "rnd_b");
        end

        // tx_en dropped on clock 10 of 0xA5 with a second word queued
        r = 8'($urandom_range(0, 255));
        ws = {};
        ws.push_back(32'hA5);
        build_model(0, ws);
        @(posedge clk);
        #1;
        acc_first = -1;
        fork
            begin
                push(0, 32'hA5);
                push(0, {24'd0, r});
            end
            begin
                t = 0;
                @(negedge clk);
                while (!(acc_first >= 0 && cyc == acc_first + 11) && t < 100) begin
                    @(negedge clk);
                    t++;
                end
                check("abort_bit9", ddr_p_a, exp_q[9]);
                tx_en_a = 1'b0;
            end
        join
        @(negedge clk);
        check("abort_quad", quad(0), 4'b0100);
        check("abort_ready", rdy(0), 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("abort_hold_quad", quad(0), 4'b0100);
        end
        tx_en_a = 1'b1;
        @(negedge clk);
        check("abort_ready_flushed", rdy(0), 1'b1);
        repeat (40) begin
            @(negedge clk);
            check("abort_reenable_idle", quad(0), 4'b0100);
        end

        // Asynchronous reset in the middle of a bit
        @(posedge clk);
        #1;
        acc_first = -1;
        push(0, 32'hA5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mid_pre", ddr_p_a, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_mid_quad_a", quad(0), 4'b0100);
        check("rst_mid_ready_a", rdy(0), 1'b0);
        check("rst_mid_quad_b", quad(1), 4'b1000);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        ws = {};
        ws.push_back(32'h3C);
        run_stream(0, ws, 1'b0, "post_rst_3c");

        // word_valid held while tx_en is low, then tx_en raised
        tx_en_a = 1'b0;
        r = 8'($urandom_range(0, 255));
        if_a.word_in = r;
        if_a.word_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("en_low_ready", rdy(0), 1'b0);
            check("en_low_quad", quad(0), 4'b0100);
        end
        ws = {};
        ws.push_back({24'd0, r});
        run_stream(0, ws, 1'b1, "en_raise");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_manchester_word_encoder
`default_nettype wire

// File: doc/manchester_word_encoder.md
Name: manchester_word_encoder

Overview:
Parametrised successor to the 100 MHz single-bit Manchester encoder. It accepts whole words over a valid/ready handshake and serialises them MSB- or LSB-first. Clocks per half-bit and encoding polarity are configurable. A one-word holding register lets consecutive words stream with no idle gap. It drives the complementary ddr_p/ddr_n pair feeding the coax line driver and flags underrun when the stream starves.

Parameters:
DATA_W, 8, word width in bits (1..32)
HALF_CLKS, 2, clk_sys cycles per half-bit (>=1). The default gives 4 clocks/bit = 25 Mbps at 100 MHz.
MSB_FIRST, 1, 1 = send bit DATA_W-1 first; 0 = send bit 0 first
POLARITY, 0, 0 = Thomas (1->high,low; 0->low,high); 1 = IEEE 802.3 (1->low,high; 0->high,low)
IDLE_LEVEL, 0, ddr_p level when not transmitting

Ports:
clk_sys  in  1  system clock
rst  in  1  asynchronous, active-high reset
tx_en  in  1  transmit enable; low = abort and flush
word_in  in  DATA_W  word to send
word_valid  in  1  word_in valid
word_ready  out  1  holding register can accept a word
ddr_p  out  1  Manchester output, registered
ddr_n  out  1  always ~ddr_p, registered
busy  out  1  a word is being shifted out
underrun  out  1  one-cycle pulse: stream ended with no next word queued

Behaviour:
- Reset (async, rst=1):
  - ddr_p=IDLE_LEVEL, ddr_n=~IDLE_LEVEL, busy=0, underrun=0, word_ready=0.
  - Hold register and shift register are empty; state=IDLE.
  - Reset takes effect immediately, including mid-word. No partial-bit completion.
- word_ready = tx_en & ~hold_full. This is combinational from registered state.
- Accept: word_valid & word_ready at a rising edge writes word_in into hold and sets hold_full.
- State IDLE:
  - ddr_p=IDLE_LEVEL.
  - If hold_full and tx_en: load shift<=hold, clear hold_full, bit_cnt<=0, half<=0, half_cnt<=0, go to SHIFT.
  - A word accepted at edge T is loaded at edge T+1. Its first half-bit is on ddr_p from edge T+2, i.e. 2-cycle latency.
- State SHIFT:
  - Current bit b = shift[DATA_W-1] if MSB_FIRST, else shift[0].
  - ddr_p = (b ^ POLARITY) during the first half and ~(b ^ POLARITY) during the second half. Each half lasts exactly HALF_CLKS cycles.
  - half_cnt counts 0..HALF_CLKS-1. At wrap, half toggles. At the end of the second half, shift moves one place toward the output end and bit_cnt increments.
  - End of the last half of bit DATA_W-1:
    - If hold_full: reload shift from hold, clear hold_full, stay in SHIFT. The next word's first half-bit appears on the very next cycle, so there is no gap.
    - Else: go to IDLE and pulse underrun for 1 cycle, aligned with the first idle-level cycle.
  - busy=1 throughout SHIFT.
- A simultaneous accept and reload at the same edge is legal. Hold is consumed and refilled in the same cycle, so hold_full stays 1.
- tx_en low, at any time:
  - Next edge: state=IDLE, hold_full=0, shift cleared, ddr_p=IDLE_LEVEL, busy=0.
  - No underrun pulse. Words not yet transmitted are discarded.
- Sustained throughput: one word every DATA_W*2*HALF_CLKS cycles.
- Counter widths: $clog2(HALF_CLKS) (min 1) for half_cnt; $clog2(DATA_W) (min 1) for bit_cnt.
- Invariant: ddr_n == ~ddr_p on every cycle, including reset.

Decomposition:
- Package manchester_pkg:
  - POL_THOMAS=0, POL_IEEE=1 constants
  - state enum {ST_IDLE, ST_SHIFT}
  - function encoding half-bit level from (bit, half, polarity)
- Sub-module manchester_halfbit_timer (parameter HALF_CLKS):
  - Inputs: clk_sys, rst, run.
  - Outputs: half (phase), half_end and bit_end strobes.
  - Reused by the matching decoder's reference timing.

Test Plan:
1. Defaults, send 0xA5 after reset. ddr_p over 32 clocks = 1100 0011 1100 0011 0011 1100 0011 1100. ddr_n is its complement every cycle. One underrun pulse, then IDLE_LEVEL.
2. Back-to-back 0xFF then 0x00 (second valid held while word_ready low). 64 contiguous encoded clocks, no idle cycle between words. Throughput measured 25 Mbps ±0. Exactly one underrun at the end.
3. POLARITY=1, MSB_FIRST=0, HALF_CLKS=3, DATA_W=4, word 0x1. First bit (1) gives ddr_p 000111. The next three bits give 111000 each; total 24 clocks.
4. tx_en dropped at clock 10 of 0xA5 with a second word queued. ddr_p=IDLE_LEVEL from the next edge, busy=0, word_ready=0, no underrun. Re-enabling with no new word keeps ddr_p idle.
5. rst asserted mid-bit, between clock edges. ddr_p/ddr_n go to idle levels immediately, without waiting for an edge. After release, a new 0x3C encodes correctly from its first half-bit.
6. word_valid asserted with tx_en low. No accept and ddr_p stays idle. Raising tx_en leads to accept on the first edge and the first half-bit 2 cycles later.
